// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, frame results, column decode.
// Pure declarations; no latency and no flow control.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_RELEASE_DB
    } state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_res_t;

    // Number of active columns, saturating at 2 ("two or more").
    function automatic logic [1:0] col_count(input logic [COLS-1:0] cols);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < COLS; i++) begin
            n = n + {2'b00, cols[i]};
        end
        return (n >= 3'd2) ? 2'd2 : n[1:0];
    endfunction

    // Index of the lowest active column; only meaningful when exactly one is set.
    function automatic logic [1:0] col_index(input logic [COLS-1:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (cols[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous column sense lines.
// Latency 2 clk cycles; no backpressure (free-running sampler).
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-based press/release debounce and multi-key detection.
// Pulses follow the qualifying frame end by 1 cycle; no backpressure, events are single-cycle pulses.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [3:0]  key_code,
    output logic        key_press,
    output logic        key_valid,
    output logic        key_release,
    output logic        multi_key
);

    localparam int            CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0]    DB_TGT    = 4'(DEBOUNCE_FRAMES);

    logic [COLS-1:0] col_sync;

    keypad_sync #(.W(COLS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col_in),
        .q     (col_sync)
    );

    // Scan timing and per-frame accumulation
    logic [CW-1:0] slot_q;
    logic [1:0]    row_q;
    logic [3:0]    row_out_q;
    logic [1:0]    acc_n_q;
    logic [3:0]    acc_code_q;

    logic          slot_last;
    logic          frame_end;
    logic [1:0]    cur_n;
    logic [3:0]    cur_code;
    logic [2:0]    sum_n;
    logic [1:0]    tot_n;
    logic [3:0]    tot_code;
    frame_res_t    frame_res;

    assign slot_last = (slot_q == SLOT_LAST);
    assign frame_end = slot_last && (row_q == 2'd3);
    assign cur_n     = col_count(col_sync);
    assign cur_code  = {row_q, col_index(col_sync)};
    assign sum_n     = {1'b0, acc_n_q} + {1'b0, cur_n};
    assign tot_n     = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    assign tot_code  = (cur_n == 2'd1) ? cur_code : acc_code_q;

    always_comb begin
        frame_res = FR_NONE;
        if (tot_n == 2'd1) begin
            frame_res = FR_SINGLE;
        end else if (tot_n == 2'd2) begin
            frame_res = FR_MULTI;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_q     <= '0;
            row_q      <= 2'd0;
            row_out_q  <= 4'b0001;
            acc_n_q    <= 2'd0;
            acc_code_q <= 4'd0;
        end else if (slot_last) begin
            slot_q    <= '0;
            row_q     <= row_q + 2'd1;
            row_out_q <= {row_out_q[2:0], row_out_q[3]};
            if (frame_end) begin
                acc_n_q    <= 2'd0;
                acc_code_q <= 4'd0;
            end else begin
                acc_n_q    <= tot_n;
                acc_code_q <= tot_code;
            end
        end else begin
            slot_q <= slot_q + 1'b1;
        end
    end

    // Debounce FSM
    state_t     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] dbc_q, dbc_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_press_q, key_press_d;
    logic       key_release_q, key_release_d;
    logic       multi_key_q, multi_key_d;

    logic       single;
    logic       match;
    logic [3:0] dbc_inc;

    assign single  = (frame_res == FR_SINGLE);
    assign match   = single && (tot_code == key_code_q);
    assign dbc_inc = (dbc_q == 4'hF) ? 4'hF : dbc_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        dbc_d         = dbc_q;
        key_code_d    = key_code_q;
        key_valid_d   = key_valid_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
        multi_key_d   = multi_key_q;

        if (frame_end) begin
            multi_key_d = (frame_res == FR_MULTI);
            case (state_q)
                ST_IDLE: begin
                    if (single) begin
                        if (DB_TGT <= 4'd1) begin
                            state_d     = ST_HELD;
                            key_code_d  = tot_code;
                            key_valid_d = 1'b1;
                            key_press_d = 1'b1;
                            dbc_d       = 4'd0;
                        end else begin
                            state_d = ST_PRESS_DB;
                            cand_d  = tot_code;
                            dbc_d   = 4'd1;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (single && (tot_code == cand_q)) begin
                        dbc_d = dbc_inc;
                        if (dbc_inc >= DB_TGT) begin
                            state_d     = ST_HELD;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_press_d = 1'b1;
                            dbc_d       = 4'd0;
                        end
                    end else if (single) begin
                        cand_d = tot_code;
                        dbc_d  = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        dbc_d   = 4'd0;
                    end
                end
                ST_HELD: begin
                    if (!match) begin
                        if (DB_TGT <= 4'd1) begin
                            state_d       = ST_IDLE;
                            key_valid_d   = 1'b0;
                            key_release_d = 1'b1;
                            dbc_d         = 4'd0;
                        end else begin
                            state_d = ST_RELEASE_DB;
                            dbc_d   = 4'd1;
                        end
                    end
                end
                ST_RELEASE_DB: begin
                    if (match) begin
                        state_d = ST_HELD;
                        dbc_d   = 4'd0;
                    end else begin
                        dbc_d = dbc_inc;
                        if (dbc_inc >= DB_TGT) begin
                            state_d       = ST_IDLE;
                            key_valid_d   = 1'b0;
                            key_release_d = 1'b1;
                            dbc_d         = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dbc_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cand_q        <= 4'd0;
            dbc_q         <= 4'd0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            multi_key_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            dbc_q         <= dbc_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            multi_key_q   <= multi_key_d;
        end
    end

    assign row_out     = row_out_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign multi_key   = multi_key_q;

endmodule
